// File: rtl/fib_stream_gen_pkg.sv
// fib_pkg: shared types and helpers for the two-term recurrence stream generator.
//   state_e  : controller states IDLE / RUN / DONE
//   mode_e   : MODE_STOP ends the run on N-bit overflow, MODE_WRAP wraps modulo 2^N
//   ovf_next : true when the next term (held N+1 bits wide) is not representable in N bits
//   is_last  : final-term qualifier, used by the RTL and by the bench scoreboard
//   fib_ref  : term k of the sequence from the seeds (bench reference model)
// Helpers take values zero-extended to fixed maximum widths (65-bit term, 32-bit index)
// so that one function serves every N/IW parameterisation.
package fib_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic {MODE_STOP = 1'b0, MODE_WRAP = 1'b1} mode_e;

  function automatic logic ovf_next(input logic [64:0] b, input int unsigned n,
                                    input mode_e mode);
    return (mode == MODE_STOP) && (b >= (65'(1) << n));
  endfunction

  function automatic logic is_last(input logic [64:0] b, input int unsigned n,
                                   input logic [31:0] idx, input logic [31:0] len,
                                   input mode_e mode);
    return ovf_next(b, n, mode) || ((len != '0) && (idx == len - 32'd1));
  endfunction

  function automatic logic [64:0] fib_ref(input logic [63:0] s0, input logic [63:0] s1,
                                          input int unsigned k, input int unsigned n,
                                          input mode_e mode);
    logic [64:0] x, y, t, msk;
    x   = 65'(s0);
    y   = 65'(s1);
    msk = (65'(1) << n) - 65'(1);
    for (int unsigned i = 0; i < k; i++) begin
      t = x + y;
      if (mode == MODE_WRAP) t = t & msk;
      x = y;
      y = t;
    end
    return x;
  endfunction

endpackage

// File: rtl/fib_stream_gen_if.sv
// fib_stream_gen_if: term stream of the generator.
//   fn        : current term (N bits)
//   out_valid : fn holds a valid term
//   out_ready : consumer accepts fn
//   idx       : index of the current term (IW bits)
//   last      : fn is the final term of the run
// master = generator side, slave = consumer side.
interface fib_stream_gen_if #(
  parameter int unsigned N  = 16,
  parameter int unsigned IW = 8
);
  logic [N-1:0]  fn;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] idx;
  logic          last;

  modport master (output fn, output out_valid, output idx, output last, input out_ready);
  modport slave  (input fn, input out_valid, input idx, input last, output out_ready);
endinterface

// File: rtl/fib_stream_gen.sv
// fib_stream_gen: streams a two-term additive recurrence with programmable seeds.
//   clk, reset      : rising-edge clock, asynchronous active-low reset
//   start, abort    : run control pulses (abort has priority)
//   seed0, seed1    : first two terms, sampled on an accepted start
//   mode, len       : 0 = stop on overflow / 1 = wrap; term count (0 = unlimited)
//   busy, done, ovf : RUN, DONE, and run-ended-by-overflow status
//   strm            : term stream (fn, out_valid, out_ready, idx, last)
module fib_stream_gen
  import fib_pkg::*;
#(
  parameter int unsigned N  = 16,
  parameter int unsigned IW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [N-1:0]  seed0,
  input  logic [N-1:0]  seed1,
  input  logic          mode,
  input  logic [IW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          ovf,
  fib_stream_gen_if.master strm
);

  state_e        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N:0]    b_q, b_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] len_q, len_d;
  mode_e         mode_q, mode_d;
  logic          ovf_q, ovf_d;
  logic          valid_q, busy_q, done_q;

  logic [N:0]    nxt;
  logic          last_c;
  logic          ovf_c;

  always_comb begin
    nxt     = {1'b0, a_q} + {1'b0, b_q[N-1:0]};
    ovf_c   = ovf_next(65'(b_q), N, mode_q);
    last_c  = (state_q == RUN) && is_last(65'(b_q), N, 32'(idx_q), 32'(len_q), mode_q);

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    len_d   = len_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;

    if (abort) begin
      state_d = IDLE;
      a_d     = '0;
      b_d     = '0;
      idx_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = RUN;
            a_d     = seed0;
            b_d     = {1'b0, seed1};
            mode_d  = mode_e'(mode);
            len_d   = len;
            idx_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        RUN: begin
          if (strm.out_ready) begin
            if (last_c) begin
              // a/idx are left alone so fn/idx keep showing the final term in DONE
              state_d = DONE;
              ovf_d   = ovf_c;
            end else begin
              a_d   = b_q[N-1:0];
              // stop mode keeps the carry in b[N] so overflow is seen one term ahead
              b_d   = (mode_q == MODE_STOP) ? nxt : {1'b0, nxt[N-1:0]};
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      mode_q  <= MODE_STOP;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
      valid_q <= (state_d == RUN);
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign strm.fn        = a_q;
  assign strm.idx       = idx_q;
  assign strm.out_valid = valid_q;
  assign strm.last      = last_c;
  assign busy           = busy_q;
  assign done           = done_q;
  assign ovf            = ovf_q;

endmodule

// File: tb/tb_fib_stream_gen.sv
module tb_fib_stream_gen;
  import fib_pkg::*;

  localparam int unsigned IW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // instance 0: N=16
  logic          start0, abort0, mode0, busy0, done0, ovf0;
  logic [15:0]   s00, s10;
  logic [IW-1:0] len0;
  // instance 1: N=8
  logic          start1, abort1, mode1, busy1, done1, ovf1;
  logic [7:0]    s01, s11;
  logic [IW-1:0] len1;

  fib_stream_gen_if #(.N(16), .IW(IW)) if0 ();
  fib_stream_gen_if #(.N(8),  .IW(IW)) if1 ();

  fib_stream_gen #(.N(16), .IW(IW)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .abort(abort0),
    .seed0(s00), .seed1(s10), .mode(mode0), .len(len0),
    .busy(busy0), .done(done0), .ovf(ovf0), .strm(if0.master));

  fib_stream_gen #(.N(8), .IW(IW)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1),
    .seed0(s01), .seed1(s11), .mode(mode1), .len(len1),
    .busy(busy1), .done(done1), .ovf(ovf1), .strm(if1.master));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  // ---------------- reference model (per instance) ----------------
  bit           m_act  [2];
  bit           m_done [2];
  bit           m_ovf  [2];
  int unsigned  m_k    [2];
  logic [63:0]  m_s0   [2];
  logic [63:0]  m_s1   [2];
  mode_e        m_mode [2];
  logic [31:0]  m_len  [2];
  logic [63:0]  m_hfn  [2];
  logic [31:0]  m_hidx [2];
  int unsigned  m_n    [2] = '{16, 8};
  logic [63:0]  cap0[$];
  logic [63:0]  cap1[$];

  task automatic step(input int i, input logic rst, input logic st, input logic ab,
                      input logic rdy, input logic [63:0] s0, input logic [63:0] s1,
                      input logic md, input logic [31:0] ln, input logic [63:0] fn,
                      input logic v, input logic [31:0] idx, input logic lst,
                      input logic bsy, input logic dn, input logic ov);
    logic [63:0] efn;
    logic [31:0] eidx;
    logic        elast;
    logic [64:0] nx;
    string       p;
    p  = (i == 0) ? "n16" : "n8";
    nx = '0;
    if (!rst) begin
      chk({p, "_rst_valid"}, 64'(v), 0);
      chk({p, "_rst_fn"}, fn, 0);
      chk({p, "_rst_idx"}, 64'(idx), 0);
      chk({p, "_rst_last"}, 64'(lst), 0);
      chk({p, "_rst_busy"}, 64'(bsy), 0);
      chk({p, "_rst_done"}, 64'(dn), 0);
      chk({p, "_rst_ovf"}, 64'(ov), 0);
      m_act[i] = 0; m_done[i] = 0; m_ovf[i] = 0; m_hfn[i] = '0; m_hidx[i] = '0;
      return;
    end
    if (m_act[i]) begin
      efn   = 64'(fib_ref(m_s0[i], m_s1[i], m_k[i], m_n[i], m_mode[i]));
      eidx  = m_k[i] % (32'd1 << IW);
      nx    = fib_ref(m_s0[i], m_s1[i], m_k[i] + 1, m_n[i], m_mode[i]);
      elast = is_last(nx, m_n[i], eidx, m_len[i], m_mode[i]);
    end else begin
      efn   = m_hfn[i];
      eidx  = m_hidx[i];
      elast = 1'b0;
    end
    chk({p, "_valid"}, 64'(v), 64'(m_act[i]));
    chk({p, "_busy"}, 64'(bsy), 64'(m_act[i]));
    chk({p, "_done"}, 64'(dn), 64'(m_done[i]));
    chk({p, "_ovf"}, 64'(ov), 64'(m_ovf[i]));
    chk({p, "_fn"}, fn, efn);
    chk({p, "_idx"}, 64'(idx), 64'(eidx));
    chk({p, "_last"}, 64'(lst), 64'(elast));

    if (ab) begin
      m_act[i] = 0; m_done[i] = 0; m_ovf[i] = 0; m_hfn[i] = '0; m_hidx[i] = '0;
    end else if (st && !m_act[i]) begin
      m_s0[i] = s0; m_s1[i] = s1; m_mode[i] = mode_e'(md); m_len[i] = ln;
      m_k[i] = 0; m_act[i] = 1; m_done[i] = 0; m_ovf[i] = 0;
    end else if (m_act[i] && rdy) begin
      if (i == 0) cap0.push_back(efn); else cap1.push_back(efn);
      if (elast) begin
        m_act[i] = 0; m_done[i] = 1;
        m_ovf[i] = ovf_next(nx, m_n[i], m_mode[i]);
        m_hfn[i] = efn; m_hidx[i] = eidx;
      end else begin
        m_k[i]++;
      end
    end
  endtask

  always @(negedge clk) begin
    step(0, reset, start0, abort0, if0.out_ready, 64'(s00), 64'(s10), mode0, 32'(len0),
         64'(if0.fn), if0.out_valid, 32'(if0.idx), if0.last, busy0, done0, ovf0);
    step(1, reset, start1, abort1, if1.out_ready, 64'(s01), 64'(s11), mode1, 32'(len1),
         64'(if1.fn), if1.out_valid, 32'(if1.idx), if1.last, busy1, done1, ovf1);
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start(input int i);
    if (i == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    if (i == 0) start0 = 1'b0; else start1 = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    for (int c = 0; c < budget; c++) begin
      if ((i == 0) ? done0 : done1) return;
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL wait_done%0d: done=0 after %0d cycles, required 1", i, budget);
  endtask

  task automatic wait_idx(input int i, input int unsigned k, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (i == 0 && if0.out_valid && if0.idx == IW'(k)) return;
      if (i == 1 && if1.out_valid && if1.idx == IW'(k)) return;
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL wait_idx%0d: idx %0d not reached, required within %0d cycles", i, k, budget);
  endtask

  logic [63:0] exp2 [12] = '{2, 1, 3, 4, 7, 11, 18, 29, 47, 76, 123, 199};
  logic [63:0] ref1[$];
  logic [63:0] tmp;
  bit          done4;

  initial begin
    reset = 1'b0;
    start0 = 0; abort0 = 0; mode0 = 0; s00 = '0; s10 = '0; len0 = '0; if0.out_ready = 0;
    start1 = 0; abort1 = 0; mode1 = 0; s01 = '0; s11 = '0; len1 = '0; if1.out_ready = 0;

    // model pinned to hand-computed terms
    tmp = 64'(fib_ref(0, 1, 24, 16, MODE_STOP)); chk("pin_fib24", tmp, 46368);
    tmp = 64'(fib_ref(2, 1, 11, 8, MODE_STOP));  chk("pin_lucas11", tmp, 199);
    tmp = 64'(fib_ref(0, 1, 14, 8, MODE_WRAP));  chk("pin_wrap14", tmp, 121);
    tmp = 64'(fib_ref(0, 1, 15, 8, MODE_WRAP));  chk("pin_wrap15", tmp, 98);
    tmp = 64'(is_last(65'd75025, 16, 32'd24, 32'd0, MODE_STOP)); chk("pin_last_ovf", tmp, 1);
    tmp = 64'(is_last(65'd65535, 16, 32'd5, 32'd0, MODE_STOP));  chk("pin_last_max", tmp, 0);

    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // case 1: Fibonacci N=16, stop mode
    cap0.delete();
    s00 = 16'd0; s10 = 16'd1; mode0 = 1'b0; len0 = '0; if0.out_ready = 1'b1;
    pulse_start(0);
    chk("c1_first_fn", 64'(if0.fn), 0);
    wait_done(0, 100);
    chk("c1_count", 64'(cap0.size()), 25);
    if (cap0.size() == 25) chk("c1_term24", cap0[24], 46368);
    chk("c1_idx_done", 64'(if0.idx), 24);
    chk("c1_ovf", 64'(ovf0), 1);
    ref1 = cap0;

    // case 4: same run, random backpressure
    cap0.delete();
    pulse_start(0);
    done4 = 0;
    for (int c = 0; c < 400; c++) begin
      if (done0) begin done4 = 1; break; end
      if0.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    chk("c4_done", 64'(done4), 1);
    chk("c4_count", 64'(cap0.size()), 25);
    if (cap0.size() == ref1.size())
      foreach (cap0[j]) chk($sformatf("c4_term%0d", j), cap0[j], ref1[j]);
    if0.out_ready = 1'b1;

    // case 5: abort + start + transfer at idx=5
    pulse_start(0);
    wait_idx(0, 5, 20);
    abort0 = 1'b1; start0 = 1'b1; s00 = 16'd3; s10 = 16'd4;
    @(posedge clk); #1;
    abort0 = 1'b0; start0 = 1'b0;
    chk("c5_valid", 64'(if0.out_valid), 0);
    chk("c5_fn", 64'(if0.fn), 0);
    chk("c5_idx", 64'(if0.idx), 0);
    pulse_start(0);
    chk("c5_restart_fn", 64'(if0.fn), 3);
    chk("c5_restart_idx", 64'(if0.idx), 0);
    wait_done(0, 100);

    // case 2: Lucas N=8, stop mode
    cap1.delete();
    s01 = 8'd2; s11 = 8'd1; mode1 = 1'b0; len1 = '0; if1.out_ready = 1'b1;
    pulse_start(1);
    wait_done(1, 50);
    chk("c2_count", 64'(cap1.size()), 12);
    if (cap1.size() == 12) foreach (exp2[j]) chk($sformatf("c2_term%0d", j), cap1[j], exp2[j]);
    chk("c2_idx_done", 64'(if1.idx), 11);
    chk("c2_ovf", 64'(ovf1), 1);

    // case 6: restart from DONE clears ovf, then reset mid-run
    s01 = 8'd0; s11 = 8'd1;
    pulse_start(1);
    chk("c6_ovf_cleared", 64'(ovf1), 0);
    wait_idx(1, 7, 20);
    reset = 1'b0;
    #1;
    chk("c6_rst_fn", 64'(if1.fn), 0);
    chk("c6_rst_valid", 64'(if1.out_valid), 0);
    chk("c6_rst_idx", 64'(if1.idx), 0);
    chk("c6_rst_busy", 64'(busy1), 0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    cap1.delete();
    pulse_start(1);
    chk("c6_fn0", 64'(if1.fn), 0);
    chk("c6_idx0", 64'(if1.idx), 0);
    @(posedge clk); #1;
    chk("c6_fn1", 64'(if1.fn), 1);
    wait_done(1, 50);
    chk("c6_count", 64'(cap1.size()), 14);
    chk("c6_idx_done", 64'(if1.idx), 13);

    // case 3: wrap mode N=8, len=16
    cap1.delete();
    s01 = 8'd0; s11 = 8'd1; mode1 = 1'b1; len1 = 8'd16;
    pulse_start(1);
    wait_done(1, 50);
    chk("c3_count", 64'(cap1.size()), 16);
    if (cap1.size() == 16) begin
      chk("c3_term13", cap1[13], 233);
      chk("c3_term14", cap1[14], 121);
      chk("c3_term15", cap1[15], 98);
    end
    chk("c3_done", 64'(done1), 1);
    chk("c3_ovf", 64'(ovf1), 0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
